// File: rtl/lambda_pkg.sv
// Shared definitions for the lambda memory controller.
// FSM encoding and SRAM address width.
package lambda_pkg;

    localparam int ADDR_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/lambda_mem_ctrl_if.sv
// LLR in-stream, lambda out-stream and SRAM port of the controller.
// master = controller side, slave = environment side.
interface lambda_mem_ctrl_if
    import lambda_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic              i_llr_valid;
    logic [WIDTH-1:0]  i_llr_data;
    logic              o_llr_ready;

    logic              o_lambda_valid;
    logic [WIDTH-1:0]  o_lambda_data;
    logic              o_lambda_last;
    logic              i_lambda_ready;

    logic              o_sram_wen;
    logic [ADDR_W-1:0] o_sram_waddr;
    logic [ADDR_W-1:0] o_sram_raddr;
    logic [WIDTH-1:0]  o_sram_wdata;
    logic [WIDTH-1:0]  i_sram_rdata;

    modport master (
        input  i_llr_valid, i_llr_data, i_lambda_ready, i_sram_rdata,
        output o_llr_ready, o_lambda_valid, o_lambda_data, o_lambda_last,
        output o_sram_wen, o_sram_waddr, o_sram_raddr, o_sram_wdata
    );

    modport slave (
        output i_llr_valid, i_llr_data, i_lambda_ready, i_sram_rdata,
        input  o_llr_ready, o_lambda_valid, o_lambda_data, o_lambda_last,
        input  o_sram_wen, o_sram_waddr, o_sram_raddr, o_sram_wdata
    );

endinterface

// File: rtl/lambda_skid.sv
// Two-entry skid buffer holding SRAM read data plus its last flag.
// Entry e0 is always the head.
module lambda_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic [1:0]       count
);
    logic [WIDTH:0] e0;
    logic [WIDTH:0] e1;
    logic [WIDTH:0] din;

    assign din       = {push_last, push_data};
    assign head_data = e0[WIDTH-1:0];
    assign head_last = e0[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            e0    <= '0;
            e1    <= '0;
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lambda_mem_ctrl.sv
// Lambda (LLR) memory controller: loads one frame into SRAM, then
// streams it back LOOP_MAX times through a 2-entry skid buffer.
module lambda_mem_ctrl
    import lambda_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ROW_NUMBER = 512,
    parameter int LOOP_MAX   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load_start,
    input  logic             i_read_start,
    lambda_mem_ctrl_if.master bus,
    output logic             o_busy,
    output logic             o_done
);
    localparam int AW = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1;
    localparam int PW = $clog2(LOOP_MAX + 1);
    localparam logic [AW-1:0] LAST_ROW  = AW'(ROW_NUMBER - 1);
    localparam logic [PW-1:0] PASSES    = PW'(LOOP_MAX);
    localparam logic [PW-1:0] LAST_PASS = PW'(LOOP_MAX - 1);

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   wcnt;
    logic [AW-1:0]   rcnt;
    logic [AW-1:0]   raddr_q;
    logic [PW-1:0]   ipass;
    logic [PW-1:0]   opass;
    logic            inflight;
    logic            inflight_last;
    logic            wr_fire;
    logic            rd_issue;
    logic            lam_valid;
    logic            pop;
    logic [2:0]      occ;
    logic [1:0]      sk_count;
    logic [WIDTH-1:0] sk_data;
    logic            sk_last;

    assign wr_fire   = (state == LOAD) && bus.i_llr_valid;
    assign lam_valid = (sk_count != 2'd0);
    assign pop       = lam_valid && bus.i_lambda_ready;

    // Crediting this cycle's pop keeps one word per cycle in steady state.
    assign occ      = {1'b0, sk_count} + {2'b0, inflight} - {2'b0, pop};
    assign rd_issue = (state == READ) && (ipass != PASSES)
                   && (sk_count != 2'd2) && (occ < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_load_start)      state_nxt = LOAD;
                else if (i_read_start) state_nxt = READ;
            end
            LOAD: if (wr_fire && wcnt == LAST_ROW) state_nxt = IDLE;
            READ: if (pop && sk_last && opass == LAST_PASS) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt          <= '0;
            rcnt          <= '0;
            raddr_q       <= '0;
            ipass         <= '0;
            opass         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rd_issue;
            inflight_last <= rd_issue && (rcnt == LAST_ROW);
            if (wr_fire) wcnt <= (wcnt == LAST_ROW) ? '0 : wcnt + 1'b1;
            if (rd_issue) begin
                raddr_q <= rcnt;
                if (rcnt == LAST_ROW) begin
                    rcnt  <= '0;
                    ipass <= ipass + 1'b1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
            if (pop && sk_last) opass <= opass + 1'b1;
            if (state == IDLE) begin
                rcnt  <= '0;
                ipass <= '0;
                opass <= '0;
            end
        end
    end

    lambda_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.i_sram_rdata),
        .push_last (inflight_last),
        .pop       (pop),
        .head_data (sk_data),
        .head_last (sk_last),
        .count     (sk_count)
    );

    always_comb begin
        bus.o_llr_ready    = (state == LOAD);
        bus.o_sram_wen     = wr_fire;
        bus.o_sram_waddr   = wr_fire ? ADDR_W'(wcnt) : '0;
        bus.o_sram_wdata   = wr_fire ? bus.i_llr_data : '0;
        bus.o_sram_raddr   = ADDR_W'(rd_issue ? rcnt : raddr_q);
        bus.o_lambda_valid = lam_valid;
        bus.o_lambda_data  = lam_valid ? sk_data : '0;
        bus.o_lambda_last  = lam_valid && sk_last;
        o_busy             = (state != IDLE);
        o_done             = (state == DONE);
    end

endmodule

// File: tb/tb_lambda_mem_ctrl.sv
// Scoreboard bench for lambda_mem_ctrl: random loads/reads against
// a frame-level reference memory.
module tb_lambda_mem_ctrl;
    localparam int W     = 8;
    localparam int ROWS  = 8;
    localparam int LOOPS = 2;
    localparam int AB    = $clog2(ROWS);

    typedef struct {
        logic [19:0]  addr;
        logic [W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_load_start = 1'b0;
    logic i_read_start = 1'b0;
    logic o_busy;
    logic o_done;

    lambda_mem_ctrl_if #(.WIDTH(W)) bus ();

    lambda_mem_ctrl #(
        .WIDTH      (W),
        .ROW_NUMBER (ROWS),
        .LOOP_MAX   (LOOPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_load_start (i_load_start),
        .i_read_start (i_read_start),
        .bus          (bus.master),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] sram [ROWS];
    logic [W-1:0] ref_mem [ROWS];

    always @(posedge clk) begin
        if (bus.o_sram_wen) sram[bus.o_sram_waddr[AB-1:0]] <= bus.o_sram_wdata;
        else bus.i_sram_rdata <= sram[bus.o_sram_raddr[AB-1:0]];
    end

    wr_t          wq [$];
    logic [W:0]   rq [$];
    wr_t          w_exp;
    logic [W:0]   r_exp;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int popped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compares every write and every lambda transfer.
    always @(negedge clk) begin
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.o_sram_wen) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                w_exp = wq.pop_front();
                chk("waddr", 32'(bus.o_sram_waddr), 32'(w_exp.addr));
                chk("wdata", 32'(bus.o_sram_wdata), 32'(w_exp.data));
            end
        end else if (wq.size() != 0) begin
            chk("missing_write", 32'd0, 32'd1);
            void'(wq.pop_front());
        end
        if (bus.o_lambda_valid && bus.i_lambda_ready) begin
            if (rq.size() == 0) begin
                chk("unexpected_lambda", 32'd1, 32'd0);
            end else begin
                r_exp = rq.pop_front();
                chk("lambda_data", 32'(bus.o_lambda_data), 32'(r_exp[W-1:0]));
                chk("lambda_last", 32'(bus.o_lambda_last), 32'(r_exp[W]));
                popped++;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_flags"},
            32'({o_busy, o_done, bus.o_llr_ready, bus.o_lambda_valid,
                 bus.o_lambda_last, bus.o_sram_wen}), 32'd0);
        chk({tag, "_waddr"}, 32'(bus.o_sram_waddr), 32'd0);
        chk({tag, "_raddr"}, 32'(bus.o_sram_raddr), 32'd0);
        chk({tag, "_data"}, 32'({bus.o_sram_wdata, bus.o_lambda_data}), 32'd0);
    endtask

    task automatic do_load(input int gap_pct, input bit rnd, input bit both);
        int k;
        int n;
        logic [W-1:0] d;
        i_load_start = 1'b1;
        i_read_start = both;
        @(posedge clk); #1;
        i_load_start = 1'b0;
        i_read_start = 1'b0;
        chk("load_entered", 32'(bus.o_llr_ready), 32'd1);
        k = 0;
        n = 0;
        while (k < ROWS && n < 500) begin
            bus.i_llr_valid = ($urandom_range(99) >= gap_pct);
            d = rnd ? W'($urandom) : W'(8'h10 + k);
            bus.i_llr_data = d;
            i_read_start = (n == 2);
            if (bus.i_llr_valid) wq.push_back(wr_t'{20'(k), d});
            @(posedge clk); #1;
            if (bus.i_llr_valid) begin
                ref_mem[k] = d;
                k++;
            end
            n++;
        end
        bus.i_llr_valid = 1'b0;
        i_read_start = 1'b0;
        chk("load_words", 32'(k), 32'(ROWS));
        if (gap_pct == 0) chk("load_cycles", 32'(n), 32'(ROWS));
        chk("busy_after_load", 32'(o_busy), 32'd0);
        chk("ready_after_load", 32'(bus.o_llr_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("read_start_ignored", 32'({o_busy, bus.o_lambda_valid}), 32'd0);
    endtask

    task automatic do_read(input int rdy_pct, input int abort_at);
        int n;
        int start;
        int d0;
        for (int p = 0; p < LOOPS; p++)
            for (int a = 0; a < ROWS; a++)
                rq.push_back({(a == ROWS - 1), ref_mem[a]});
        d0 = done_cnt;
        popped = 0;
        i_read_start = 1'b1;
        start = cyc;
        @(posedge clk); #1;
        i_read_start = 1'b0;
        chk("read_entered", 32'(o_busy), 32'd1);
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            if (abort_at >= 0 && popped >= abort_at) break;
            bus.i_lambda_ready = ($urandom_range(99) < rdy_pct);
            @(posedge clk); #1;
            n++;
        end
        if (abort_at >= 0) begin
            rst = 1'b1;
            bus.i_lambda_ready = 1'b0;
            @(posedge clk); #1;
            check_zero("abort");
            rst = 1'b0;
            rq.delete();
            chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        end else begin
            if (rdy_pct == 100)
                chk("read_latency", 32'(done_cyc - start), 32'(3 + ROWS * LOOPS));
            repeat (3) @(posedge clk);
            #1;
            chk("done_once", 32'(done_cnt - d0), 32'd1);
            chk("idle_after_done", 32'(o_busy), 32'd0);
            chk("all_words_out", 32'(rq.size()), 32'd0);
        end
        bus.i_lambda_ready = 1'b0;
        rq.delete();
    endtask

    initial begin
        for (int i = 0; i < ROWS; i++) sram[i] = '0;
        bus.i_llr_valid    = 1'b0;
        bus.i_llr_data     = '0;
        bus.i_lambda_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        do_load(0, 1'b0, 1'b0);
        do_read(100, -1);
        do_read(50, -1);
        do_load(40, 1'b1, 1'b1);
        do_read(50, -1);
        do_read(100, 3);
        @(posedge clk); #1;
        do_read(60, -1);
        do_read(100, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lambda_mem_ctrl.md
LAMBDA_MEM_CTRL -- requirements
Module: lambda_mem_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of one lambda (LLR) word.
REQ-002 SHALL have parameter ROW_NUMBER, default 512, number of lambda words stored (SRAM depth).
REQ-003 SHALL have parameter LOOP_MAX, default 4, number of full read passes per decode.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_load_start  input  1  pulse; begin load phase.
REQ-007 SHALL have ports i_llr_valid input 1 / i_llr_data input WIDTH / o_llr_ready output 1  inbound LLR stream; a word transfers when valid&ready.
REQ-008 SHALL have port i_read_start  input  1  pulse; begin read phase.
REQ-009 SHALL have ports o_lambda_valid output 1 / o_lambda_data output WIDTH / o_lambda_last output 1 / i_lambda_ready input 1  outbound lambda stream; a word transfers when valid&ready; last marks word ROW_NUMBER-1 of each pass.
REQ-010 SHALL have ports o_sram_wen output 1 / o_sram_waddr output 20 / o_sram_raddr output 20 / o_sram_wdata output WIDTH / i_sram_rdata input WIDTH  SRAM master port (write when wen=1; registered read, 1-cycle latency, only when wen=0).
REQ-011 SHALL have ports o_busy output 1 (state != IDLE) and o_done output 1 (one-cycle pulse at end of final pass).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, READ, DONE.
REQ-013 IDLE: i_load_start -> LOAD; else i_read_start -> READ; both asserted same cycle -> LOAD wins.
REQ-014 LOAD: o_llr_ready=1; each transfer drives o_sram_wen=1, o_sram_waddr=write counter, o_sram_wdata=i_llr_data combinationally; counter increments per transfer.
REQ-015 LOAD: transfer at address ROW_NUMBER-1 -> counter wraps to 0, FSM -> IDLE next cycle; o_llr_ready=0 outside LOAD.
REQ-016 READ: o_sram_wen held 0; read issued at o_sram_raddr=read counter only when (skid occupancy + reads in flight) < 2.
REQ-017 Read data from i_sram_rdata SHALL be captured one cycle after issue into a 2-entry skid buffer; o_lambda_* driven from buffer head.
REQ-018 Lambda words SHALL leave in strict address order 0..ROW_NUMBER-1 per pass, no drops/duplicates under arbitrary i_lambda_ready.
REQ-019 Read counter wraps ROW_NUMBER-1 -> 0 and increments pass counter; o_lambda_last set on the word from address ROW_NUMBER-1.
REQ-020 After LOOP_MAX passes issued and buffer drained (last word of last pass transferred) -> DONE for one cycle (o_done=1) -> IDLE.
REQ-021 i_load_start/i_read_start outside IDLE SHALL be ignored.
REQ-022 SRAM address outputs SHALL be zero-extended to 20 bits; unused upper bits 0.
REQ-023 o_sram_waddr/o_sram_wdata don't-care when o_sram_wen=0; o_sram_raddr holds last value when no read issued.

Reset
REQ-024 rst SHALL force: state IDLE, counters 0, skid empty, in-flight flag 0, all outputs 0 (o_llr_ready, o_lambda_valid, o_lambda_last, o_busy, o_done, o_sram_wen, addresses, wdata).
REQ-025 rst mid-LOAD or mid-READ SHALL abort immediately; SRAM contents untouched; any SRAM read returning the cycle after reset SHALL be discarded.

Structure
REQ-026 FSM state encoding, ADDR_W=20 SHALL live in shared package lambda_pkg.
REQ-027 2-entry skid buffer SHALL be sub-module lambda_skid (WIDTH data + last bit, push/pop, count).
REQ-028 Target 150-300 lines RTL total.

Verification
REQ-029 Load ROW_NUMBER=8, data 0x10..0x17 with valid always 1 -> 8 writes addr 0..7, o_busy falls cycle after addr 7.
REQ-030 Read, LOOP_MAX=2, i_lambda_ready=1 -> 16 outputs 0x10..0x17 twice, last on 8th and 16th, o_done pulse once, sustained 1 word/cycle after 2-cycle startup.
REQ-031 Read with i_lambda_ready random 50% -> identical ordered sequence, never >2 buffered, no read issued while full.
REQ-032 i_load_start and i_read_start same cycle in IDLE -> LOAD entered; i_read_start during LOAD ignored.
REQ-033 rst asserted mid-READ at word 3 -> next cycle all outputs 0, state IDLE; subsequent read restarts at address 0 with original data.
REQ-034 i_llr_valid gaps during LOAD -> o_sram_wen only on transfer cycles, addresses contiguous.
